// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared definitions: command codes, FSM states, defaults.
// Also used by the CPU side for the command constants.
package mem_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 9;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RDATA,
    ACK
  } state_t;

  // 2'b11 is deliberately not a request
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: two-way tie-break, fixed priority or round-robin.
// RR_EN selects round-robin using last_grant.
module mem_arb_pick #(
  parameter bit RR_EN = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       win
);

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req == 2'b11): win = RR_EN ? ~last_grant : 1'b0;
      (req == 2'b10): win = 1'b1;
      default:        win = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two requesters onto one synchronous single-port RAM.
// Define MEM_ARB_RR_EN for round-robin; default is fixed priority (r0).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        r0_cmd,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic [1:0]        r1_cmd,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-2:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              err_oob
);

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_t state, nxt;

  logic [1:0]        req;
  logic              win;
  logic              grant;
  logic [1:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_oob;

  logic              l_id;
  logic              l_oob;
  logic [ADDR_W-2:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              last_grant;

  assign req     = {is_req(r1_cmd), is_req(r0_cmd)};
  assign w_cmd   = win ? r1_cmd   : r0_cmd;
  assign w_addr  = win ? r1_addr  : r0_addr;
  assign w_wdata = win ? r1_wdata : r0_wdata;
  assign w_oob   = w_addr[ADDR_W-1];
  assign grant   = (state == IDLE) && (|req);

  mem_arb_pick #(
    .RR_EN(RR_EN)
  ) u_pick (
    .req       (req),
    .last_grant(last_grant),
    .win       (win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    ram_write = 1'b0;
    r0_ack    = 1'b0;
    r1_ack    = 1'b0;
    err_oob   = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          if (w_oob)                nxt = ACK;
          else if (w_cmd == MWRITE) nxt = WR;
          else                      nxt = RD;
        end
      end
      WR: begin
        ram_write = 1'b1;
        nxt       = ACK;
      end
      RD:    nxt = RDATA;
      RDATA: nxt = ACK;
      ACK: begin
        r0_ack  = ~l_id;
        r1_ack  = l_id;
        err_oob = l_oob;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Winner is latched once on leaving IDLE; RAM ports hold it afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_id       <= 1'b0;
      l_oob      <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      last_grant <= 1'b1;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      if (grant) begin
        l_id    <= win;
        l_oob   <= w_oob;
        l_addr  <= w_addr[ADDR_W-2:0];
        l_wdata <= w_wdata;
`ifdef MEM_ARB_RR_EN
        last_grant <= win;
`endif
        if (w_oob && w_cmd == MREAD) begin
          if (win) r1_rdata <= '0;
          else     r0_rdata <= '0;
        end
      end
      if (state == RDATA) begin
        if (l_id) r1_rdata <= ram_dout;
        else      r0_rdata <= ram_dout;
      end
    end
  end

  assign ram_addr = l_addr;
  assign ram_din  = l_wdata;

endmodule
